// File: rtl/modadd_pkg.sv
// Shared defaults and the S1 stage layout for the modular-add arbiter.
// Round-robin arbitration is selected by defining MODADD_ARB_RR_EN.
package modadd_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ID_W       = $clog2(DEF_NUM_REQ);

  // S1 stage contents at the default sizing; the top re-declares the same
  // layout sized by its own parameters.
  typedef struct packed {
    logic                      valid;
    logic [DEF_ID_W-1:0]       id;
    logic [DEF_DATA_WIDTH-1:0] a;
    logic [DEF_DATA_WIDTH-1:0] b;
  } s1_stage_t;

endpackage : modadd_pkg

// File: rtl/modadd_core.sv
// Combinational (a + b) mod m with an out-of-range operand flag.
// Only a single conditional subtract is applied, so in-range operands are exact.
module modadd_core
  import modadd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [DATA_WIDTH-1:0] i_m,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_err
);

  logic [DATA_WIDTH:0] w_sum;
  logic                w_wrap;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_wrap = (w_sum >= {1'b0, i_m});

  // Low bits of (sum - m) equal the truncated DATA_WIDTH-bit difference.
  assign o_data = w_wrap ? (w_sum[DATA_WIDTH-1:0] - i_m) : w_sum[DATA_WIDTH-1:0];
  assign o_err  = (i_a >= i_m) || (i_b >= i_m);

endmodule : modadd_core

// File: rtl/modadd_arbiter.sv
// NUM_REQ requesters share one two-stage modular-add pipeline.
// MODADD_ARB_RR_EN defined: round-robin grant; undefined: fixed priority (lowest index).
module modadd_arbiter
  import modadd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          cfg_m_we,
  input  logic [DATA_WIDTH-1:0]         cfg_m,
  output logic                          cfg_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err
);

  typedef struct packed {
    logic                  valid;
    logic [ID_W-1:0]       id;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } s1_t;

  s1_t                   r_s1;
  logic [DATA_WIDTH-1:0] r_m;
  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;

  logic                  w_s2_adv;
  logic                  w_cfg_fire;
  logic                  w_can_grant;
  logic                  w_gnt_any;
  logic                  w_grant;
  logic [ID_W-1:0]       w_gnt_idx;
  logic [DATA_WIDTH-1:0] w_sel_a;
  logic [DATA_WIDTH-1:0] w_sel_b;
  logic [DATA_WIDTH-1:0] w_core_data;
  logic                  w_core_err;

`ifdef MODADD_ARB_RR_EN
  logic [ID_W-1:0]       r_ptr;
`endif

  // S2 frees up when empty or draining; S1 follows S2 directly.
  assign w_s2_adv    = !r_rsp_valid || rsp_ready;
  assign cfg_ready   = !r_s1.valid && !r_rsp_valid;
  assign w_cfg_fire  = cfg_m_we && cfg_ready;
  assign w_can_grant = (r_m != '0) && !w_cfg_fire && (!r_s1.valid || w_s2_adv);
  assign w_grant     = w_gnt_any && w_can_grant;

  // NOTE: every always_comb output gets a default before any branch so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
`ifdef MODADD_ARB_RR_EN
    // First pass covers pointer..NUM_REQ-1, second pass wraps to 0..pointer-1.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_gnt_any && req_valid[i] && (ID_W'(i) >= r_ptr)) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = ID_W'(i);
        w_sel_a   = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_b   = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_gnt_any && req_valid[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = ID_W'(i);
        w_sel_a   = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_b   = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_gnt_any && req_valid[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = ID_W'(i);
        w_sel_a   = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_b   = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_grant && (w_gnt_idx == ID_W'(i));
    end
  end

  modadd_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .i_a   (r_s1.a),
    .i_b   (r_s1.b),
    .i_m   (r_m),
    .o_data(w_core_data),
    .o_err (w_core_err)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1        <= '0;
      r_m         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_cfg_fire) begin
        r_m <= cfg_m;
      end
      if (w_s2_adv) begin
        r_rsp_valid <= r_s1.valid;
        if (r_s1.valid) begin
          r_rsp_id   <= r_s1.id;
          r_rsp_data <= w_core_data;
          r_rsp_err  <= w_core_err;
        end
      end
      if (w_grant) begin
        r_s1 <= '{valid: 1'b1, id: w_gnt_idx, a: w_sel_a, b: w_sel_b};
      end else if (w_s2_adv) begin
        r_s1.valid <= 1'b0;
      end
    end
  end

`ifdef MODADD_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end
`endif

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  a_no_grant_without_m : assert property (@(posedge clk) disable iff (!rst_n)
    (r_m == '0) |-> (req_ready == '0));

  a_rsp_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) &&
                                   $stable(rsp_data) && $stable(rsp_err)));

endmodule : modadd_arbiter

// File: tb/tb_modadd_arbiter.sv
// Directed bench for modadd_arbiter with a scoreboard of expected responses.
// Grant-order expectations follow MODADD_ARB_RR_EN when it is defined.
module tb_modadd_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR-1:0]  req_ready;
  logic           cfg_m_we;
  logic [DW-1:0]  cfg_m;
  logic           cfg_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [DW-1:0]  rsp_data;
  logic           rsp_err;

  always #5 clk = ~clk;

  modadd_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .ID_W      (IW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .cfg_m_we (cfg_m_we),
    .cfg_m    (cfg_m),
    .cfg_ready(cfg_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  logic [DW-1:0] op_a[NR];
  logic [DW-1:0] op_b[NR];
  int            rem[NR];
  logic [DW-1:0] m_model;

  logic [NR-1:0] obs_ready;
  logic          obs_rsp_valid;
  logic          obs_cfg_ready;
  logic [IW-1:0] obs_id;
  logic [DW-1:0] obs_data;
  logic          obs_err;
  logic          popped;

  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [DW-1:0] m);
    exp_t e;
    int   s;
    s      = int'(a) + int'(b);
    if (s >= int'(m)) s = s - int'(m);
    e.id   = IW'(id);
    e.data = DW'(s);
    e.err  = (int'(a) >= int'(m)) || (int'(b) >= int'(m));
    return e;
  endfunction

  // One clock: observe at the falling edge, then update requesters after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    obs_ready     = req_ready;
    obs_rsp_valid = rsp_valid;
    obs_cfg_ready = cfg_ready;
    obs_id        = rsp_id;
    obs_data      = rsp_data;
    obs_err       = rsp_err;
    popped        = 1'b0;
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_id", rsp_id, e.id);
        chk("sb_data", rsp_data, e.data);
        chk("sb_err", rsp_err, e.err);
        popped = 1'b1;
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] && req_valid[i]) sb.push_back(model(i, op_a[i], op_b[i], m_model));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (obs_ready[i] && req_valid[i]) begin
        if (rem[i] > 0) begin
          rem[i]--;
          op_a[i] = DW'($urandom);
          op_b[i] = DW'($urandom);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic start(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input int n);
    op_a[i]      = a;
    op_b[i]      = b;
    rem[i]       = n - 1;
    req_valid[i] = 1'b1;
  endtask

  task automatic cfg_write(input logic [DW-1:0] m, input logic expect_accept);
    cfg_m_we = 1'b1;
    cfg_m    = m;
    step();
    cfg_m_we = 1'b0;
    chk("cfg_ready", obs_cfg_ready, expect_accept);
    if (expect_accept) m_model = m;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((req_valid != '0 || sb.size() != 0 || rsp_valid) && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) chk("drain_timeout", k, 0);
  endtask

  task automatic run_one(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int k;
    start(i, a, b, 1);
    k = 0;
    do begin
      step();
      k++;
    end while (!popped && k < 12);
    if (!popped) chk("run_one_timeout", popped, 1);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    cfg_m_we  = 1'b0;
    cfg_m     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rem[i]  = 0;
      op_a[i] = '0;
      op_b[i] = '0;
    end
    sb.delete();
    m_model = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] gnt_seq [5];
    logic [IW-1:0] hold_id;
    logic [DW-1:0] hold_data;
    logic          hold_err;
    int            k;

    do_reset();

    // Reset state: nothing granted while the modulus is still zero.
    start(0, 8'd7, 8'd9, 1);
    step();
    chk("rst_rsp_valid", obs_rsp_valid, 0);
    chk("rst_rsp_id", obs_id, 0);
    chk("rst_rsp_data", obs_data, 0);
    chk("rst_rsp_err", obs_err, 0);
    chk("rst_req_ready", obs_ready, 0);
    chk("rst_cfg_ready", obs_cfg_ready, 1);

    // Basic add with exact two-cycle latency; cfg write blocks the grant that cycle.
    cfg_write(8'd13, 1'b1);
    chk("cfg_blocks_grant", obs_ready, 0);
    step();
    chk("req022_grant", obs_ready, 4'b0001);
    step();
    chk("req022_lat1", obs_rsp_valid, 0);
    step();
    chk("req022_lat2", obs_rsp_valid, 1);
    chk("req022_data", obs_data, 3);
    chk("req022_id", obs_id, 0);
    chk("req022_err", obs_err, 0);

    // sum == m yields zero; 9-bit carry case with m = 255.
    run_one(1, 8'd6, 8'd7);
    chk("req023_zero", obs_data, 0);
    chk("req023_id", obs_id, 1);
    cfg_write(8'd255, 1'b1);
    run_one(2, 8'd200, 8'd100);
    chk("req023_carry", obs_data, 45);
    chk("req023_carry_err", obs_err, 0);

    // Arbitration with all four requesters continuously valid.
    do_reset();
    cfg_write(8'd13, 1'b1);
`ifdef MODADD_ARB_RR_EN
    gnt_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    gnt_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    for (int i = 0; i < NR; i++) start(i, DW'(i + 1), DW'(i + 2), 30);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("req024_gnt%0d", c), obs_ready, gnt_seq[c]);
      if (c >= 2) chk($sformatf("req024_thru%0d", c), obs_rsp_valid, 1);
    end
    req_valid = '0;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    drain();

    // Backpressure: five stalled cycles hold the response and stop grants.
    start(1, 8'd3, 8'd4, 8);
    start(3, 8'd5, 8'd6, 8);
    repeat (3) step();
    rsp_ready = 1'b0;
    step();
    chk("req025_valid0", obs_rsp_valid, 1);
    chk("req025_gnt0", obs_ready, 0);
    hold_id   = obs_id;
    hold_data = obs_data;
    hold_err  = obs_err;
    for (int c = 1; c < 5; c++) begin
      step();
      chk($sformatf("req025_valid%0d", c), obs_rsp_valid, 1);
      chk($sformatf("req025_id%0d", c), obs_id, hold_id);
      chk($sformatf("req025_data%0d", c), obs_data, hold_data);
      chk($sformatf("req025_err%0d", c), obs_err, hold_err);
      chk($sformatf("req025_gnt%0d", c), obs_ready, 0);
      chk($sformatf("req025_inflight%0d", c), 32'(sb.size() <= 2), 1);
    end
    rsp_ready = 1'b1;
    drain();

    // Modulus write with operations in flight is ignored; accepted after drain.
    start(0, 8'd1, 8'd2, 10);
    repeat (3) step();
    cfg_write(8'd7, 1'b0);
    drain();
    cfg_write(8'd7, 1'b1);
    run_one(0, 8'd5, 8'd14);
    chk("req026_err", obs_err, 1);
    chk("req026_data", obs_data, 12);

    // Reset mid-stream drops everything immediately; no grants until a new modulus.
    start(0, 8'd2, 8'd3, 10);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("req027_async_valid", rsp_valid, 0);
    chk("req027_async_ready", req_ready, 0);
    sb.delete();
    m_model = '0;
    rem[0]  = 0;
    op_a[0] = 8'd2;
    op_b[0] = 8'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("req027_quiet%0d", c), obs_rsp_valid, 0);
      chk($sformatf("req027_noready%0d", c), obs_ready, 0);
    end
    cfg_write(8'd13, 1'b1);
    k = 0;
    do begin
      step();
      k++;
    end while (!popped && k < 12);
    if (!popped) chk("req027_timeout", popped, 1);
    chk("req027_data", obs_data, 5);
    chk("req027_id", obs_id, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_modadd_arbiter

// File: doc/modadd_arbiter.md
MODADD_ARBITER -- requirements
Module: modadd_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, operand/modulus width; NUM_REQ, 4, requester count (2..16); ID_W, $clog2(NUM_REQ), requester-id width.
REQ-002 Ports SHALL be: clk  in  1  clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 Ports SHALL be: req_valid  in  NUM_REQ  per-requester request; req_a, req_b  in  NUM_REQ*DATA_WIDTH  packed operands, slot i at [i*DATA_WIDTH +: DATA_WIDTH]; req_ready  out  NUM_REQ  per-requester accept.
REQ-004 Ports SHALL be: cfg_m_we  in  1  modulus write strobe; cfg_m  in  DATA_WIDTH  new modulus; cfg_ready  out  1  modulus write accepted.
REQ-005 Ports SHALL be: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  ID_W  originating requester; rsp_data  out  DATA_WIDTH  (a+b) mod m; rsp_err  out  1  operand out of range.

Function
REQ-006 Block SHALL share one modular-add datapath among NUM_REQ requesters; a transfer occurs on requester i when req_valid[i] and req_ready[i] are both high on a clk edge.
REQ-007 req_ready SHALL be one-hot or zero, combinationally derived; at most one grant per cycle; a raised req_valid SHALL stay high with stable operands until granted.
REQ-008 Grant SHALL be allowed only when m_q != 0, no accepted cfg write this cycle, and stage S1 is empty or advancing.
REQ-009 Pipeline SHALL be two registered stages: S1 holds {valid, id, a, b}; S2 holds rsp_*; latency from grant edge to rsp_valid SHALL be exactly 2 cycles with rsp_ready high.
REQ-010 Arithmetic: sum computed at DATA_WIDTH+1 bits; if sum >= m_q then rsp_data = sum - m_q, else rsp_data = sum[DATA_WIDTH-1:0]; sum == m_q SHALL yield 0.
REQ-011 rsp_err SHALL be 1 when a >= m_q or b >= m_q; rsp_data is still produced per REQ-010 truncated to DATA_WIDTH.
REQ-012 Backpressure: rsp_valid & !rsp_ready SHALL hold S2 and rsp_* stable; S1 SHALL hold if full; no grant while S1 full and holding.
REQ-013 Full throughput: with rsp_ready high and requests pending, one result per cycle.
REQ-014 cfg_ready SHALL be high only when S1 and S2 are empty; cfg_m_we & cfg_ready loads m_q at that edge and blocks grants in that cycle; cfg_m_we while cfg_ready low SHALL be ignored.
REQ-015 Responses SHALL return in grant order; ids never reordered or dropped.

Reset
REQ-016 rst_n low SHALL asynchronously clear S1/S2 valid, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, m_q=0, arbitration pointer=0; req_ready=0 while m_q==0.
REQ-017 Reset mid-operation SHALL discard in-flight operations without emitting responses; deassertion used synchronously to clk.

Configuration
REQ-018 Macro MODADD_ARB_RR_EN defined: round-robin; pointer moves to granted index+1 (wraps NUM_REQ-1 -> 0) on each grant; search starts at pointer.
REQ-019 Macro undefined: fixed priority, lowest index wins; pointer logic absent.

Structure
REQ-020 Package modadd_pkg SHALL hold default DATA_WIDTH, NUM_REQ, and typedef of the S1 stage struct {valid, id, a, b}.
REQ-021 Sub-module modadd_core SHALL implement REQ-010/REQ-011 combinationally; registers stay in modadd_arbiter.

Verification
REQ-022 Reset, cfg_m=13, req0 a=7 b=9 -> rsp_data=3, rsp_id=0, rsp_err=0, 2 cycles after grant.
REQ-023 m=13, a=6 b=7 -> rsp_data=0; m=255 a=200 b=100 -> rsp_data=45 (9-bit carry case).
REQ-024 m=13, all four requesters valid continuously, RR_EN defined -> grants 0,1,2,3,0 in consecutive cycles; undefined -> requester 0 every cycle.
REQ-025 rsp_ready low 5 cycles with stream pending -> rsp_* stable, at most 2 in flight, no loss; order preserved after release.
REQ-026 cfg_m_we with ops in flight -> cfg_ready=0, write ignored; after drain cfg_m=7 accepted, a=5 b=14 -> rsp_err=1.
REQ-027 rst_n pulsed low mid-stream -> rsp_valid drops immediately, no stale response after release, req_ready=0 until new cfg write.
